// File: rtl/chan_sel_pkg.sv
// Shared types and limits for the channel selector: scan FSM state encoding
// and the largest supported channel count.
package chan_sel_pkg;

  localparam int CH_NUM_MAX = 16;

  typedef logic [0:0] scan_state_t;

  localparam scan_state_t MANUAL = 1'b0;
  localparam scan_state_t SCAN   = 1'b1;

endpackage

// File: rtl/chan_sel_mux_if.sv
// Data/control bundle between the channel selector and its surroundings.
// master = the block driving channel data and key pulses, slave = chan_sel_mux.
interface chan_sel_mux_if
  import chan_sel_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int WIDTH  = 8
);

  localparam int SEL_W = $clog2(CH_NUM);

  logic [CH_NUM*WIDTH-1:0] din;
  logic                    key_next;
  logic                    key_prev;
  logic                    load;
  logic [SEL_W-1:0]        load_sel;
  logic                    scan_mode;
  logic [WIDTH-1:0]        dout;
  logic [SEL_W-1:0]        sel;
  logic                    sel_change;

  modport master (
    output din, key_next, key_prev, load, load_sel, scan_mode,
    input  dout, sel, sel_change
  );

  modport slave (
    input  din, key_next, key_prev, load, load_sel, scan_mode,
    output dout, sel, sel_change
  );

endinterface

// File: rtl/sel_wrap_ctr.sv
// Modulo-CH_NUM up/down select counter with range-checked load and a
// one-cycle change pulse; manual_o flags a manual action that took effect.
module sel_wrap_ctr #(
  parameter  int CH_NUM = 4,
  localparam int SEL_W  = $clog2(CH_NUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next_i,
  input  logic             prev_i,
  input  logic             load_i,
  input  logic [SEL_W-1:0] load_sel_i,
  input  logic             tick_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             change_o,
  output logic             manual_o
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH_NUM - 1);
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CH_NUM);

  logic [SEL_W-1:0] sel_q, sel_d, sel_up, sel_dn;
  logic             change_q;
  logic             load_ok;

  assign load_ok  = load_i && ({1'b0, load_sel_i} < CH_LIMIT);
  // An out-of-range load still wins priority; it just leaves sel where it is.
  assign manual_o = load_i ? load_ok : (next_i ^ prev_i);

  assign sel_up = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
  assign sel_dn = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);

  always_comb begin
    // NOTE: default assignment first so every path drives sel_d; no latch.
    sel_d = sel_q;
    if (load_i) begin
      if (load_ok) sel_d = load_sel_i;
    end else if (next_i && prev_i) begin
      sel_d = sel_q;
    end else if (next_i) begin
      sel_d = sel_up;
    end else if (prev_i) begin
      sel_d = sel_dn;
    end else if (tick_i) begin
      sel_d = sel_up;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking updates so both flops see the same pre-edge sel_q.
    if (!reset) begin
      sel_q    <= '0;
      change_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      change_q <= (sel_d != sel_q);
    end
  end

  assign sel_o    = sel_q;
  assign change_o = change_q;

endmodule

// File: rtl/chan_sel_mux.sv
// Registered N-channel data selector stepped by key pulses, with direct load.
// Define CHAN_SEL_AUTOSCAN_EN to build the timed auto-scan FSM and dwell counter.
module chan_sel_mux
  import chan_sel_pkg::*;
#(
  parameter int CH_NUM   = 4,
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic          clk,
  input  logic          reset,
  chan_sel_mux_if.slave bus
);

  localparam int SEL_W = $clog2(CH_NUM);

  if (CH_NUM < 2 || CH_NUM > CH_NUM_MAX || SCAN_DIV < 2) begin : g_param_check
    $error("chan_sel_mux: CH_NUM must be 2..%0d and SCAN_DIV >= 2", CH_NUM_MAX);
  end

  logic [SEL_W-1:0] sel;
  logic             sel_change;
  logic             manual;
  logic             tick;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] ch_data [CH_NUM];

  sel_wrap_ctr #(.CH_NUM(CH_NUM)) u_sel_ctr (
    .clk        (clk),
    .reset      (reset),
    .next_i     (bus.key_next),
    .prev_i     (bus.key_prev),
    .load_i     (bus.load),
    .load_sel_i (bus.load_sel),
    .tick_i     (tick),
    .sel_o      (sel),
    .change_o   (sel_change),
    .manual_o   (manual)
  );

`ifdef CHAN_SEL_AUTOSCAN_EN
  localparam int                DW      = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]     DW_LAST = DW'(SCAN_DIV - 1);

  scan_state_t   state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;

  // A manual action restarts the dwell so a full period always follows it.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    tick    = 1'b0;
    case (state_q)
      MANUAL: begin
        dwell_d = '0;
        if (bus.scan_mode) state_d = SCAN;
      end
      SCAN: begin
        if (!bus.scan_mode) begin
          state_d = MANUAL;
          dwell_d = '0;
        end else if (manual) begin
          dwell_d = '0;
        end else if (dwell_q == DW_LAST) begin
          tick    = 1'b1;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MANUAL;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end
`else
  localparam int UNUSED_SCAN_DIV = SCAN_DIV;
  logic unused_scan;

  assign tick        = 1'b0;
  assign unused_scan = bus.scan_mode ^ manual;
`endif

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    assign ch_data[k] = bus.din[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout_q <= '0;
    else        dout_q <= ch_data[sel];
  end

  assign bus.dout       = dout_q;
  assign bus.sel        = sel;
  assign bus.sel_change = sel_change;

endmodule

// File: tb/tb_chan_sel_mux.sv
// Scoreboard bench for chan_sel_mux (3 channels, SCAN_DIV=4): stimulus queues
// expected select events, a negedge monitor pops them on every sel_change pulse.
module tb_chan_sel_mux;

  localparam int CH_NUM   = 3;
  localparam int WIDTH    = 8;
  localparam int SCAN_DIV = 4;

  typedef struct {
    logic [1:0] sel;
    int         at;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  int         cyc   = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       exp_q[$];
  logic       dout_pending = 1'b0;
  logic [1:0] pend_sel = '0;
  logic [7:0] ch_val [CH_NUM];

  chan_sel_mux_if #(.CH_NUM(CH_NUM), .WIDTH(WIDTH)) bus ();

  chan_sel_mux #(
    .CH_NUM   (CH_NUM),
    .WIDTH    (WIDTH),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every sel_change pulse must match the oldest queued event, and
  // the following cycle dout must carry that channel's data.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (dout_pending) begin
      check("dout_follows_sel", 32'(bus.dout), 32'(ch_val[pend_sel]));
      dout_pending = 1'b0;
    end
    if (bus.sel_change === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sel_change", 32'(bus.sel_change), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sel_new", 32'(bus.sel), 32'(e.sel));
        check("sel_change_cycle", cyc, e.at);
        dout_pending = 1'b1;
        pend_sel     = e.sel;
      end
    end
  end

  task automatic drive(input logic nx, input logic pv, input logic ld, input logic [1:0] ls,
                       input logic chg, input logic [1:0] exp_sel, input string name);
    @(posedge clk); #1;
    bus.key_next = nx;
    bus.key_prev = pv;
    bus.load     = ld;
    bus.load_sel = ls;
    if (chg) exp_q.push_back('{sel: exp_sel, at: cyc + 1});
    @(posedge clk); #1;
    bus.key_next = 1'b0;
    bus.key_prev = 1'b0;
    bus.load     = 1'b0;
    bus.load_sel = '0;
    repeat (2) @(negedge clk);
    check(name, 32'(bus.sel), 32'(exp_sel));
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sel"},        32'(bus.sel),        32'd0);
    check({tag, "_dout"},       32'(bus.dout),       32'd0);
    check({tag, "_sel_change"}, 32'(bus.sel_change), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c;
    ch_val[0] = 8'hA0;
    ch_val[1] = 8'hB1;
    ch_val[2] = 8'hC2;
    bus.din       = {ch_val[2], ch_val[1], ch_val[0]};
    bus.key_next  = 1'b0;
    bus.key_prev  = 1'b0;
    bus.load      = 1'b0;
    bus.load_sel  = '0;
    bus.scan_mode = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_state("in_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_sel",        32'(bus.sel),        32'd0);
    check("post_rst_dout",       32'(bus.dout),       32'hA0);
    check("post_rst_sel_change", 32'(bus.sel_change), 32'd0);

    // nx   pv   ld   ls  chg  sel_after
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, "next_0_to_1");
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, "next_1_to_2");
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, "next_wrap_to_0");
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, "prev_wrap_to_2");
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd2, "both_keys_hold");
    drive(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 2'd2, "load_out_of_range");
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, "load_beats_next");
    drive(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, "load_same_sel");
    drive(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, "load_to_2");
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, "next_2_to_0");

`ifdef CHAN_SEL_AUTOSCAN_EN
    @(posedge clk); #1;
    bus.scan_mode = 1'b1;
    c = cyc;
    exp_q.push_back('{sel: 2'd1, at: c + 1 + SCAN_DIV});
    exp_q.push_back('{sel: 2'd2, at: c + 1 + 2*SCAN_DIV});
    wait_cyc(c + 2 + 2*SCAN_DIV);
    bus.key_next = 1'b1;
    exp_q.push_back('{sel: 2'd0, at: c + 3 + 2*SCAN_DIV});
    @(posedge clk); #1;
    bus.key_next = 1'b0;
    exp_q.push_back('{sel: 2'd1, at: c + 3 + 3*SCAN_DIV});
    exp_q.push_back('{sel: 2'd2, at: c + 3 + 4*SCAN_DIV});
    wait_cyc(c + 5 + 4*SCAN_DIV);
    check("scan_sel_before_reset", 32'(bus.sel), 32'd2);
    reset         = 1'b0;
    bus.scan_mode = 1'b0;
    #1;
    check_reset_state("scan_async_rst");
`else
    @(posedge clk); #1;
    bus.scan_mode = 1'b1;
    repeat (100) @(negedge clk);
    check("noscan_sel_const", 32'(bus.sel), 32'd0);
    @(posedge clk); #1;
    bus.scan_mode = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, "load_2_before_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_state("manual_async_rst");
`endif

    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_after_release", 32'(bus.sel), 32'd0);

    @(posedge clk); #1;
    ch_val[0] = 8'h5A;
    bus.din   = {ch_val[2], ch_val[1], ch_val[0]};
    @(negedge clk);
    check("din_latency_old", 32'(bus.dout), 32'hA0);
    @(negedge clk);
    check("din_latency_new", 32'(bus.dout), 32'h5A);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chan_sel_mux.md
# chan_sel_mux

Registered N-channel data selector whose active channel is stepped by debounced key pulses, with wrap-around, direct channel load and an optional timed auto-scan mode. It sits between a bank of parallel data sources (display digits, LED patterns, sensor words) and a single downstream consumer. It takes its key pulses from the key-debounce block.

## Interface
- CH_NUM, 4, number of input channels; legal range 2..16, need not be a power of two
- WIDTH, 8, bits per channel
- SCAN_DIV, 50_000_000, dwell time per channel in auto-scan, in clk cycles; must be ≥2
- SEL_W (local), $clog2(CH_NUM), select width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- din  in  CH_NUM*WIDTH  channel data; channel k occupies din[k*WIDTH +: WIDTH]
- key_next  in  1  single-cycle pulse: advance to next channel
- key_prev  in  1  single-cycle pulse: step to previous channel
- load  in  1  single-cycle pulse: jump to channel load_sel
- load_sel  in  SEL_W  target channel for load
- scan_mode  in  1  level: 1 = auto-scan requested
- dout  out  WIDTH  registered selected channel data
- sel  out  SEL_W  current channel index
- sel_change  out  1  one-cycle pulse when sel changes value

## Operation
- Reset values: sel=0, dout=0, sel_change=0, FSM=MANUAL, dwell counter=0.
- Select update priority each cycle: load > (key_next & key_prev: no change) > key_next > key_prev > scan tick > hold.
- key_next: sel = CH_NUM-1 ? 0 : sel+1. key_prev: sel = 0 ? CH_NUM-1 : sel-1.
- load with load_sel ≥ CH_NUM: ignored; sel holds and sel_change stays 0.
- load with load_sel == sel: no change; sel_change stays 0.
- sel_change is asserted in the cycle after an edge at which sel took a new value.
- dout <= din slice indexed by the current sel register, every cycle, unconditionally.
- FSM (auto-scan build only), two states:
  - MANUAL: entered from SCAN when scan_mode is sampled 0; the dwell counter clears to 0.
  - SCAN: entered from MANUAL when scan_mode is sampled 1; the dwell counter starts at 0.
  - In SCAN the dwell counter counts 0..SCAN_DIV-1. Reaching SCAN_DIV-1 produces a scan tick, which advances sel as key_next does, and the counter returns to 0.
  - In SCAN, any key_next, key_prev or valid load applies normally and clears the dwell counter to 0, so a full dwell always follows a manual action.
- Inputs are synchronous to clk and already debounced; no internal synchronisers.

## Timing
- Key, load or tick sampled at edge t → sel new at t; sel_change=1 during t..t+1; dout shows the new channel after edge t+1. Control-to-data latency is 2 edges.
- Data latency is 1 cycle: a din change with sel unchanged appears on dout after the next edge.
- Scan period is exactly SCAN_DIV cycles between sel advances when no manual action occurs.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous); the first advance follows the first qualifying edge after reset release.

## Configuration
- CHAN_SEL_AUTOSCAN_EN defined: FSM, dwell counter and scan tick are built as described.
- CHAN_SEL_AUTOSCAN_EN undefined: no FSM and no counter. scan_mode is ignored (port kept, unused). Block behaves as permanent MANUAL.

## Structure
- Package chan_sel_pkg: FSM state typedef (MANUAL, SCAN) and the legal CH_NUM maximum constant.
- Sub-module sel_wrap_ctr: SEL_W-bit modulo-CH_NUM up/down counter with load, load-range check and change pulse. It is instantiated once.
- Top holds the FSM, the dwell counter and the output register.

## Test plan
- Reset with din channels = 8'hA0,8'hB1,8'hC2,8'hD3; release → sel=0, dout=8'hA0, sel_change=0.
- CH_NUM=3: key_next ×3 → sel 1,2,0, each with one sel_change pulse; then key_prev at sel=0 → sel=2.
- key_next and key_prev pulsed together → sel unchanged, no sel_change. load with load_sel=3 on CH_NUM=3 → ignored. load_sel=1 with key_next in the same cycle → sel=1.
- Auto-scan build, SCAN_DIV=4, scan_mode=1 → sel advances every 4 cycles. key_next mid-dwell → sel advances and the next tick comes 4 cycles later.
- Non-autoscan build: scan_mode=1 held for 100 cycles → sel constant.
- Assert reset during SCAN with sel=2 → sel=0, dout=0 at once; after release in MANUAL, sel holds with no keys.
